extend_unit: RTL and testbench
==============================

EXTEND_UNIT -- requirements
Module: Extend

Interface
Parameters: none; all widths are fixed (RV32 immediate generation).
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port instruction, input, 25 bits [31:7]: instruction word minus the opcode field, bit numbering kept as RV32 (MSB index 31, LSB index 7).
REQ-005 Port ImmSrc, input, 2 bits: immediate format select; 00=I, 01=S, 10=B, 11=J.
REQ-006 Port valid_in, input, 1 bit: the instruction/ImmSrc pair is valid this cycle.
REQ-007 Port ImmExt, output, 32 bits: registered sign-extended immediate.
REQ-008 Port valid_out, output, 1 bit: ImmExt holds a result computed from a valid input.

Function
REQ-009 The I-format result SHALL be {20 copies of instruction[31], instruction[31:20]}.
REQ-010 The S-format result SHALL be {20 copies of instruction[31], instruction[31:25], instruction[11:7]}.
REQ-011 The B-format result SHALL be {20 copies of instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}.
REQ-012 The J-format result SHALL be {12 copies of instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}.
REQ-013 Sign source SHALL always be instruction[31]; bit 0 of B and J results SHALL always be 0.
REQ-014 All four ImmSrc codes are legal; no code SHALL produce X or an error flag.
REQ-015 Latency SHALL be exactly one clock: inputs sampled on rising edge N appear on ImmExt/valid_out after edge N.
REQ-016 On an edge with valid_in=1, ImmExt SHALL load the selected result and valid_out SHALL be set to 1.
REQ-017 On an edge with valid_in=0, ImmExt SHALL hold its previous value and valid_out SHALL be set to 0.
REQ-018 Back-to-back valid inputs SHALL produce back-to-back results, one per cycle; there is no stall or backpressure.
REQ-019 Instruction bits not used by the selected format (e.g. [19:12] for I/S/B) SHALL NOT affect ImmExt.
REQ-020 The combinational decode path SHALL contain no latches; the only state is ImmExt and valid_out.

Reset
REQ-021 While rst_n=0, ImmExt SHALL be 32'h00000000 and valid_out SHALL be 0, independent of clk.
REQ-022 Reset asserted mid-stream SHALL clear both outputs immediately; a result in flight SHALL be discarded.
REQ-023 After rst_n deasserts, the first valid_in sampled on a rising edge SHALL produce a result on the next cycle.

Verification
REQ-024 I-type: instruction=25'h1000000 (only bit31 set), ImmSrc=00, valid_in=1 -> next cycle ImmExt=32'hFFFFF800, valid_out=1; instruction=0 -> 32'h00000000.
REQ-025 S-type: same two instructions, ImmSrc=01 -> 32'hFFFFF800 and 32'h00000000.
REQ-026 B-type: same two instructions, ImmSrc=10 -> 32'hFFFFF000 and 32'h00000000.
REQ-027 J-type: same two instructions, ImmSrc=11 -> 32'hFFF00000 and 32'h00000000.
REQ-028 Field mapping: instruction = RV32 word 32'h00C58463 bits [31:7], ImmSrc=10 -> 32'h00000008; the word for addi x1,x0,-1, ImmSrc=00 -> 32'hFFFFFFFF.
REQ-029 Control: valid_in=0 for one cycle -> ImmExt holds, valid_out=0; drop rst_n between clock edges -> ImmExt=0 and valid_out=0 before the next edge.

Source files
------------

// File: rtl/extend_unit_if.sv
// ---------------------------------------------------------------------------
// extend_unit_if
//
// Bundles the request/response signals of the RV32 immediate extend unit so
// the unit and whatever feeds it can be connected through a single port.
//
// Signals:
//   instruction [31:7]  instruction word without the opcode field, bit
//                       numbering kept identical to the full RV32 word
//   ImmSrc      [1:0]   immediate format select: 00=I, 01=S, 10=B, 11=J
//   valid_in            instruction/ImmSrc pair is valid this cycle
//   ImmExt      [31:0]  registered, sign-extended immediate
//   valid_out           ImmExt holds a result computed from a valid input
//
// Modports:
//   master  drives the request side and observes the result (decoder side)
//   slave   the extend unit itself
// ---------------------------------------------------------------------------
interface extend_unit_if;

  logic [31:7] instruction;
  logic [1:0]  ImmSrc;
  logic        valid_in;
  logic [31:0] ImmExt;
  logic        valid_out;

  modport master (
    output instruction,
    output ImmSrc,
    output valid_in,
    input  ImmExt,
    input  valid_out
  );

  modport slave (
    input  instruction,
    input  ImmSrc,
    input  valid_in,
    output ImmExt,
    output valid_out
  );

endinterface

// File: rtl/extend_unit.sv
// ---------------------------------------------------------------------------
// extend_unit
//
// RV32 immediate generator with a single register stage. Each cycle the
// immediate for the selected format (I, S, B or J) is assembled from the
// instruction fields and sign-extended from instruction[31]. On a clock edge
// with valid_in high the result is captured into ImmExt and valid_out is
// raised; with valid_in low ImmExt keeps its last value and valid_out drops.
// There is no backpressure: back-to-back valid inputs give back-to-back
// results with exactly one clock of latency.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset; clears ImmExt and valid_out
//   bus    extend_unit_if.slave carrying instruction, ImmSrc, valid_in
//          (inputs) and ImmExt, valid_out (outputs)
// ---------------------------------------------------------------------------
module extend_unit (
  input  logic          clk,
  input  logic          rst_n,
  extend_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_fmt_e;

  logic        sign_bit;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_sel;
  imm_fmt_e    imm_fmt;

  logic [31:0] imm_ext_d;
  logic [31:0] imm_ext_q;
  logic        valid_out_d;
  logic        valid_out_q;

  // Every format takes its sign from instruction[31], so the sign bit is
  // shared across all four assemblies below.
  assign sign_bit = bus.instruction[31];
  assign imm_fmt  = imm_fmt_e'(bus.ImmSrc);

  // Field assembly for each format. B and J immediates are halfword offsets,
  // so their bit 0 is hard-wired to zero. Bits a format does not use simply
  // never appear in its concatenation.
  always_comb begin
    imm_i = {{20{sign_bit}}, bus.instruction[31:20]};
    imm_s = {{20{sign_bit}}, bus.instruction[31:25], bus.instruction[11:7]};
    imm_b = {{20{sign_bit}}, bus.instruction[7], bus.instruction[30:25],
             bus.instruction[11:8], 1'b0};
    imm_j = {{12{sign_bit}}, bus.instruction[19:12], bus.instruction[20],
             bus.instruction[30:21], 1'b0};
  end

  // Format select. All four codes are meaningful; the default arm only exists
  // so the decode stays fully specified.
  always_comb begin
    imm_sel = imm_i;
    unique case (imm_fmt)
      IMM_I:   imm_sel = imm_i;
      IMM_S:   imm_sel = imm_s;
      IMM_B:   imm_sel = imm_b;
      IMM_J:   imm_sel = imm_j;
      default: imm_sel = imm_i;
    endcase
  end

  // Next-state: load on valid, otherwise hold the last result. valid_out just
  // tracks whether the edge that produced the current ImmExt saw valid_in.
  always_comb begin
    imm_ext_d   = imm_ext_q;
    valid_out_d = bus.valid_in;
    if (bus.valid_in) begin
      imm_ext_d = imm_sel;
    end
  end

  // Output register. Reset is asynchronous so a result in flight is dropped
  // the moment rst_n falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_ext_q   <= 32'h0000_0000;
      valid_out_q <= 1'b0;
    end else begin
      imm_ext_q   <= imm_ext_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.ImmExt    = imm_ext_q;
  assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_extend_unit.sv
// ---------------------------------------------------------------------------
// tb_extend_unit
//
// Directed bench for extend_unit. Each vector is a full 32-bit RV32 word, a
// format code and a valid flag; bits [31:7] of the word drive the unit and
// the expected immediate is worked out by hand next to each call.
// ---------------------------------------------------------------------------
module tb_extend_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  extend_unit_if bus ();

  extend_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its expected value and logs mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, observed, expected);
    end
  endtask

  // Drives one vector away from the rising edge, lets the edge sample it and
  // returns just after that edge so outputs can be read.
  task automatic applyStimulus(input logic [31:0] word, input logic [1:0] src,
                               input logic valid);
    @(negedge clk);
    bus.instruction = word[31:7];
    bus.ImmSrc      = src;
    bus.valid_in    = valid;
    @(posedge clk);
    #1;
  endtask

  // Applies a valid vector and checks both outputs one edge later.
  task automatic checkVector(input string tag, input logic [31:0] word,
                             input logic [1:0] src, input logic [31:0] expected);
    applyStimulus(word, src, 1'b1);
    checkOutput({tag, ".imm"}, bus.ImmExt, expected);
    checkOutput({tag, ".vld"}, {31'd0, bus.valid_out}, 32'd1);
  endtask

  // Safety net in case something stalls the stimulus process.
  initial begin
    #20000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors          = 0;
    checks          = 0;
    rst_n           = 1'b1;
    bus.instruction = '0;
    bus.ImmSrc      = 2'b00;
    bus.valid_in    = 1'b0;

    // Reset assertion, checked before any clock edge and again after one.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst.imm.noclk", bus.ImmExt, 32'h0000_0000);
    checkOutput("rst.vld.noclk", {31'd0, bus.valid_out}, 32'd0);
    bus.valid_in    = 1'b1;
    bus.instruction = 25'h1FF_FFFF;
    @(posedge clk);
    #1;
    checkOutput("rst.imm.clk", bus.ImmExt, 32'h0000_0000);
    checkOutput("rst.vld.clk", {31'd0, bus.valid_out}, 32'd0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n        = 1'b1;

    // Sign-only words for every format, then the all-zero word.
    checkVector("i.neg",  32'h8000_0000, 2'b00, 32'hFFFF_F800);
    checkVector("i.zero", 32'h0000_0000, 2'b00, 32'h0000_0000);
    checkVector("s.neg",  32'h8000_0000, 2'b01, 32'hFFFF_F800);
    checkVector("s.zero", 32'h0000_0000, 2'b01, 32'h0000_0000);
    checkVector("b.neg",  32'h8000_0000, 2'b10, 32'hFFFF_F000);
    checkVector("b.zero", 32'h0000_0000, 2'b10, 32'h0000_0000);
    checkVector("j.neg",  32'h8000_0000, 2'b11, 32'hFFF0_0000);
    checkVector("j.zero", 32'h0000_0000, 2'b11, 32'h0000_0000);

    // Real instructions: beq x11,x12,+8 and addi x1,x0,-1.
    checkVector("b.beq",  32'h00C5_8463, 2'b10, 32'h0000_0008);
    checkVector("i.addi", 32'hFFF0_0093, 2'b00, 32'hFFFF_FFFF);

    // Individual field positions.
    checkVector("s.lo5",    32'h0000_0F80, 2'b01, 32'h0000_001F);
    checkVector("b.bit7",   32'h0000_0080, 2'b10, 32'h0000_0800);
    checkVector("j.bit21",  32'h0020_0000, 2'b11, 32'h0000_0002);
    checkVector("j.bit20",  32'h0010_0000, 2'b11, 32'h0000_0800);
    checkVector("j.bit12",  32'h0000_1000, 2'b11, 32'h0000_1000);
    checkVector("j.hi",     32'h7FE0_0000, 2'b11, 32'h0000_07FE);

    // Bits [19:12] are unused by I, S and B.
    checkVector("i.unused", 32'h000F_F000, 2'b00, 32'h0000_0000);
    checkVector("s.unused", 32'h000F_F000, 2'b01, 32'h0000_0000);
    checkVector("b.unused", 32'h000F_F000, 2'b10, 32'h0000_0000);

    // Load a known value, then a bubble with different inputs: hold, vld=0.
    checkVector("hold.pre", 32'hFFF0_0093, 2'b00, 32'hFFFF_FFFF);
    applyStimulus(32'h0000_0000, 2'b11, 1'b0);
    checkOutput("hold.imm", bus.ImmExt, 32'hFFFF_FFFF);
    checkOutput("hold.vld", {31'd0, bus.valid_out}, 32'd0);
    checkVector("hold.post", 32'h00C5_8463, 2'b10, 32'h0000_0008);

    // Mid-stream reset between edges while a new valid is waiting.
    @(negedge clk);
    bus.instruction = 25'h100_0000;
    bus.ImmSrc      = 2'b11;
    bus.valid_in    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst.imm", bus.ImmExt, 32'h0000_0000);
    checkOutput("midrst.vld", {31'd0, bus.valid_out}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst.drop.imm", bus.ImmExt, 32'h0000_0000);
    checkOutput("midrst.drop.vld", {31'd0, bus.valid_out}, 32'd0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n        = 1'b1;

    // First valid after release appears one edge later.
    checkVector("after.rst", 32'h8000_0000, 2'b11, 32'hFFF0_0000);
    applyStimulus(32'h0000_0000, 2'b00, 1'b0);
    checkOutput("after.idle.vld", {31'd0, bus.valid_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
